led_code_sched: RTL and testbench
=================================

Name: led_code_sched

Overview:
- Shares one status LED among N_SRC activity sources.
- Latches activity requests and serves them round-robin.
- For each granted source k, blinks k+1 pulses, then holds a dark gap, so a human can identify the source from the pulse count.
- Sits between subsystem activity strobes (bus, SPI, SD, etc.) and the board LED pin.

Parameters:
- N_SRC, 4, number of requesters, legal range 2..8; ID_W = $clog2(N_SRC).
- LED_OFF, 1'b1, LED level when off (1 means the LED is active-low).
- TICK_DIV, 24'd249_999, prescaler top; one tick every TICK_DIV+1 clk cycles (10 ms at 25 MHz).
- ON_TICKS, 16'd15, LED-on phase length in ticks, must be at least 1.
- OFF_TICKS, 16'd15, LED-off phase length between pulses in ticks, must be at least 1.
- GAP_TICKS, 16'd60, dark gap after the last pulse in ticks, must be at least 1.

Ports:
- clk  in  1  system clock, 25 MHz.
- resetn  in  1  reset, asynchronous and active-low.
- en  in  1  global enable; when low, sequencing is aborted and the LED is off.
- req  in  N_SRC  activity request per source; a level-high sample sets that source's pending bit.
- led_o  out  1  LED drive.
- busy  out  1  high while in ON, OFF or GAP.
- grant_id  out  ID_W  source currently served; holds the last value while in IDLE.
- served  out  N_SRC  one-hot, one clk pulse when a source's sequence completes.

Behaviour:
- Reset values (async): led_o=LED_OFF, busy=0, grant_id=N_SRC-1, served=0, pending=0, prescaler=TICK_DIV, FSM=IDLE, tick counter=0, pulses_left=0.
- Prescaler:
  - Free-running down-counter from TICK_DIV.
  - tick is a 1-clk strobe when the prescaler reaches 0, after which it reloads.
  - The prescaler runs regardless of en and FSM state.
- Pending register:
  - pending[i] <= (pending[i] & ~clr[i]) | req[i].
  - If set and clear happen in the same cycle, set wins, so a source requesting during its own service is served again later.
  - Pending bits are kept while en=0.
- Arbitration (IDLE only):
  - Search pending starting at (grant_id+1) mod N_SRC, wrapping.
  - The first hit k is granted on the next clk edge, with no wait for a tick.
  - Latency: req high in cycle t, pending set at edge t+1, led_o on at edge t+2.
- FSM states: IDLE, ON, OFF, GAP.
  - IDLE: led_o=LED_OFF, busy=0. If en and any pending: go to ON, grant_id=k, pulses_left=k, tcnt=ON_TICKS-1, led_o=~LED_OFF.
  - ON: on a tick, if tcnt==0 go to OFF with tcnt=OFF_TICKS-1 and LED off; otherwise tcnt-1.
  - OFF: on a tick with tcnt==0:
    - if pulses_left==0, go to GAP with tcnt=GAP_TICKS-1;
    - otherwise go to ON, pulses_left-1, tcnt=ON_TICKS-1, LED on.
    - On a tick with tcnt!=0: tcnt-1.
  - GAP: LED off. On a tick with tcnt==0, go to IDLE, pulse served[grant_id] in that cycle, and clear pending[grant_id].
- Phase timing: a phase of P ticks spans P tick strobes. The first ON phase after a grant lasts between P-1 and P tick periods, because the prescaler is free-running. All later phases are exact.
- Pulse count: source k produces exactly k+1 LED-on pulses per service.
- en deassert (any state other than IDLE):
  - Next edge: FSM=IDLE, led_o=LED_OFF, busy=0.
  - No served pulse is emitted and pending is not cleared.
  - grant_id keeps the aborted source, so after en returns, arbitration resumes at grant_id+1.
- served is registered: high exactly one clk and zero otherwise.
- Counter widths: tick counter 16 bit, prescaler 24 bit, pulses_left ID_W bit. There is no overflow path because counters only count down.

Test Plan:
- Bench config for all scenarios: N_SRC=4, TICK_DIV=3, ON=2, OFF=2, GAP=3.
- Reset: hold resetn=0 mid-sequence -> led_o=1, busy=0, served=0, grant_id=3 immediately (async); after release, no activity until a req.
- Single request: 1-clk pulse on req[2] -> led_o low 2 clk later; 3 low pulses, each 8 clk long except the first (5..8 clk); 8 clk between pulses; 12 clk dark gap; then served=4'b0100 for 1 clk and busy=0.
- Round robin: req=4'b1011 held 1 clk -> service order 0,1,3 with pulse counts 1,2,4 and served pulses 0001, 0010, 1000.
- Re-request during service: req[0] pulsed while source 0 is in GAP, same cycle as clearing -> pending[0] stays set; source 0 is served again right after, unless another source is pending ahead of it in round-robin order.
- Abort: en=0 during source 1's second ON -> led_o=1 next clk, busy=0, no served pulse; en=1 -> source 1 still pending and is served again in full with 2 pulses.
- Simultaneous: all req high continuously -> services cycle 0,1,2,3,0,…; busy drops for exactly 1 clk between services.

Source files
------------

// File: rtl/led_code_sched.sv
// Shares one status LED among N_SRC activity sources.
// Each served source k blinks k+1 pulses, then the LED stays dark for a gap.
module led_code_sched #(
    parameter int unsigned N_SRC     = 4,
    parameter logic        LED_OFF   = 1'b1,
    parameter logic [23:0] TICK_DIV  = 24'd249_999,
    parameter logic [15:0] ON_TICKS  = 16'd15,
    parameter logic [15:0] OFF_TICKS = 16'd15,
    parameter logic [15:0] GAP_TICKS = 16'd60,
    localparam int unsigned ID_W     = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [N_SRC-1:0] req,
    output logic             led_o,
    output logic             busy,
    output logic [ID_W-1:0]  grant_id,
    output logic [N_SRC-1:0] served
);

    localparam int unsigned PRESC_W = 24;
    localparam int unsigned TCNT_W  = 16;
    localparam logic [N_SRC-1:0] SRC_ONE = N_SRC'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PRESC_W-1:0]  presc_q;
    logic                tick_c;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [TCNT_W-1:0]   tcnt_d;
    logic [ID_W-1:0]     pulses_q;
    logic [ID_W-1:0]     pulses_d;
    logic [ID_W-1:0]     grant_d;
    logic [ID_W-1:0]     pick_c;
    logic [ID_W-1:0]     arb_idx_c;
    logic                found_c;
    logic [N_SRC-1:0]    pending_q;
    logic [N_SRC-1:0]    clr_c;
    logic [N_SRC-1:0]    served_d;
    logic                led_d;
    logic                busy_d;

    // Free-running tick prescaler, independent of en and FSM state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= TICK_DIV;
        end else if (presc_q == '0) begin
            presc_q <= TICK_DIV;
        end else begin
            presc_q <= presc_q - PRESC_W'(1);
        end
    end

    assign tick_c = (presc_q == '0);

    // Pending requests; a new request wins over a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_c) | req;
        end
    end

    // Round-robin search starting just after the last granted source
    always_comb begin
        found_c   = 1'b0;
        pick_c    = grant_id;
        arb_idx_c = '0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            arb_idx_c = ID_W'((32'(grant_id) + i) % N_SRC);
            if (!found_c && pending_q[arb_idx_c]) begin
                found_c = 1'b1;
                pick_c  = arb_idx_c;
            end
        end
    end

    // Sequencer next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        pulses_d = pulses_q;
        grant_d  = grant_id;
        served_d = '0;
        clr_c    = '0;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_c) begin
                        state_d  = S_ON;
                        grant_d  = pick_c;
                        pulses_d = pick_c;
                        tcnt_d   = ON_TICKS - TCNT_W'(1);
                    end
                end
                S_ON: begin
                    if (tick_c) begin
                        if (tcnt_q == '0) begin
                            state_d = S_OFF;
                            tcnt_d  = OFF_TICKS - TCNT_W'(1);
                        end else begin
                            tcnt_d = tcnt_q - TCNT_W'(1);
                        end
                    end
                end
                S_OFF: begin
                    if (tick_c) begin
                        if (tcnt_q != '0) begin
                            tcnt_d = tcnt_q - TCNT_W'(1);
                        end else if (pulses_q == '0) begin
                            state_d = S_GAP;
                            tcnt_d  = GAP_TICKS - TCNT_W'(1);
                        end else begin
                            state_d  = S_ON;
                            pulses_d = pulses_q - ID_W'(1);
                            tcnt_d   = ON_TICKS - TCNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (tick_c) begin
                        if (tcnt_q == '0) begin
                            state_d  = S_IDLE;
                            served_d = SRC_ONE << grant_id;
                            clr_c    = SRC_ONE << grant_id;
                        end else begin
                            tcnt_d = tcnt_q - TCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
        led_d  = (state_d == S_ON) ? ~LED_OFF : LED_OFF;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            tcnt_q   <= '0;
            pulses_q <= '0;
            grant_id <= ID_W'(N_SRC - 1);
            served   <= '0;
            led_o    <= LED_OFF;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            pulses_q <= pulses_d;
            grant_id <= grant_d;
            served   <= served_d;
            led_o    <= led_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_led_code_sched.sv
// Testbench for led_code_sched: measures each LED service and compares it
// with a round-robin pulse-code model.
module tb_led_code_sched;

    localparam int   NS           = 4;
    localparam int   CLK_PER_TICK = 4;
    localparam int   ON_CLK       = 2 * CLK_PER_TICK;
    localparam int   OFF_CLK      = 2 * CLK_PER_TICK;
    localparam int   GAP_CLK      = 3 * CLK_PER_TICK;
    localparam int   ON_FIRST_MIN = CLK_PER_TICK + 1;
    localparam int   DARK_CLK     = OFF_CLK + GAP_CLK;
    localparam int   LIMIT        = 300;
    localparam logic LED_ON       = 1'b0;
    localparam logic LED_DARK     = 1'b1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  req;
    logic        led_o;
    logic        busy;
    logic [1:0]  grant_id;
    logic [3:0]  served;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: pending set and last granted source
    logic [3:0] m_pend;
    int         m_last;

    // Results of the latest measured service
    int         ms_id, ms_pulses, ms_gap, ms_first, ms_pre_idle, ms_busy_bad, ms_end_grant;
    int         ms_on [8];
    int         ms_off[8];
    logic [3:0] ms_served;
    logic       ms_end_busy;
    bit         ms_timeout;

    led_code_sched #(
        .N_SRC    (4),
        .LED_OFF  (1'b1),
        .TICK_DIV (24'd3),
        .ON_TICKS (16'd2),
        .OFF_TICKS(16'd2),
        .GAP_TICKS(16'd3)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .en      (en),
        .req     (req),
        .led_o   (led_o),
        .busy    (busy),
        .grant_id(grant_id),
        .served  (served)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int rr_pick(input logic [3:0] pend, input int last);
        for (int o = 1; o <= NS; o++) begin
            int idx;
            idx = (last + o) % NS;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    // Observe one service: LED pulse widths, spacing, trailing dark time, served strobe.
    // Drives req to base each cycle, and base|rr on the last dark cycle before served.
    task automatic measure_service(input logic [3:0] base, input logic [3:0] rr, input int limit);
        int run, cyc;
        bit in_on, done;
        run = 0; cyc = 0; in_on = 0; done = 0;
        ms_id = -1; ms_pulses = 0; ms_gap = -1; ms_first = -1; ms_pre_idle = 0;
        ms_busy_bad = 0; ms_end_grant = -1; ms_served = '0; ms_end_busy = 1'bx; ms_timeout = 0;
        for (int i = 0; i < 8; i++) begin ms_on[i] = 0; ms_off[i] = 0; end
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (served !== 4'b0) begin
                ms_served = served; ms_gap = run; ms_end_busy = busy;
                ms_end_grant = int'(grant_id); done = 1;
            end else if (led_o === LED_ON) begin
                if (!in_on) begin
                    if (ms_pulses > 0 && ms_pulses <= 8) ms_off[ms_pulses-1] = run;
                    ms_pulses++;
                    if (ms_pulses == 1) begin ms_id = int'(grant_id); ms_first = cyc; end
                    in_on = 1; run = 1;
                end else run++;
            end else begin
                if (in_on) begin
                    if (ms_pulses <= 8) ms_on[ms_pulses-1] = run;
                    in_on = 0; run = 1;
                end else if (ms_pulses > 0) run++;
                else if (busy === 1'b0) ms_pre_idle++;
            end
            if (!done && ms_pulses > 0 && busy !== 1'b1) ms_busy_bad++;
            req = (!done && !in_on && ms_pulses > 0 && run == DARK_CLK) ? (base | rr) : base;
            if (!done && cyc >= limit) begin ms_timeout = 1; done = 1; end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b1; en = 1'b1; req = '0;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (led_o !== 1'b1) begin n_errors++; $display("FAIL reset_led: got %b, expected 1", led_o); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (served !== 4'b0) begin n_errors++; $display("FAIL reset_served: got %b, expected 0000", served); end
        n_checks++; if (grant_id !== 2'd3) begin n_errors++; $display("FAIL reset_grant: got %0d, expected 3", grant_id); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        m_pend = '0; m_last = 3;
        begin
            int bad;
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (led_o !== LED_DARK || busy !== 1'b0 || served !== 4'b0) bad++;
            end
            n_checks++; if (bad != 0) begin n_errors++; $display("FAIL reset_idle: %0d active cycles, expected 0", bad); end
        end
    endtask

    task automatic test_round_robin;
        for (int r = 0; r < 3; r++) begin
            logic [3:0] pat;
            pat = (r == 0) ? 4'b1011 : 4'($urandom_range(1, 15));
            @(negedge clk);
            req = pat; m_pend = m_pend | pat;
            while (m_pend != 0) begin
                int e;
                logic [3:0] ex_srv;
                e = rr_pick(m_pend, m_last);
                ex_srv = 4'b0001 << e;
                measure_service(4'b0, 4'b0, LIMIT);
                n_checks++; if (ms_timeout || ms_id != e) begin n_errors++; $display("FAIL rr_grant: got id=%0d timeout=%0b, expected id=%0d", ms_id, ms_timeout, e); end
                n_checks++; if (ms_pulses != e + 1) begin n_errors++; $display("FAIL rr_pulses: got %0d, expected %0d", ms_pulses, e + 1); end
                n_checks++; if (ms_served !== ex_srv) begin n_errors++; $display("FAIL rr_served: got %b, expected %b", ms_served, ex_srv); end
                n_checks++; if (ms_gap != DARK_CLK || ms_busy_bad != 0 || ms_end_busy !== 1'b0) begin n_errors++; $display("FAIL rr_tail: dark=%0d busy_bad=%0d end_busy=%b, expected %0d/0/0", ms_gap, ms_busy_bad, ms_end_busy, DARK_CLK); end
                for (int p = 0; p < ms_pulses && p < 8; p++) begin
                    n_checks++; if ((p == 0) ? (ms_on[p] < ON_FIRST_MIN || ms_on[p] > ON_CLK) : (ms_on[p] != ON_CLK)) begin n_errors++; $display("FAIL rr_on_len: pulse %0d lasted %0d clk, expected %0d", p, ms_on[p], ON_CLK); end
                    if (p > 0) begin n_checks++; if (ms_off[p-1] != OFF_CLK) begin n_errors++; $display("FAIL rr_off_len: space %0d lasted %0d clk, expected %0d", p - 1, ms_off[p-1], OFF_CLK); end end
                end
                m_pend[e] = 1'b0; m_last = e;
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    task automatic test_single;
        int e;
        e = 2;
        @(negedge clk);
        req = 4'b0100; m_pend[2] = 1'b1;
        measure_service(4'b0, 4'b0, LIMIT);
        n_checks++; if (ms_first != 2) begin n_errors++; $display("FAIL single_latency: LED on after %0d clk, expected 2", ms_first); end
        n_checks++; if (ms_timeout || ms_id != e) begin n_errors++; $display("FAIL single_grant: got id=%0d timeout=%0b, expected id=%0d", ms_id, ms_timeout, e); end
        n_checks++; if (ms_pulses != 3) begin n_errors++; $display("FAIL single_pulses: got %0d, expected 3", ms_pulses); end
        n_checks++; if (ms_served !== 4'b0100) begin n_errors++; $display("FAIL single_served: got %b, expected 0100", ms_served); end
        n_checks++; if (ms_gap != DARK_CLK || ms_busy_bad != 0 || ms_end_busy !== 1'b0) begin n_errors++; $display("FAIL single_tail: dark=%0d busy_bad=%0d end_busy=%b, expected %0d/0/0", ms_gap, ms_busy_bad, ms_end_busy, DARK_CLK); end
        n_checks++; if (ms_end_grant != e) begin n_errors++; $display("FAIL single_grant_hold: got %0d, expected %0d", ms_end_grant, e); end
        for (int p = 0; p < ms_pulses && p < 8; p++) begin
            n_checks++; if ((p == 0) ? (ms_on[p] < ON_FIRST_MIN || ms_on[p] > ON_CLK) : (ms_on[p] != ON_CLK)) begin n_errors++; $display("FAIL single_on_len: pulse %0d lasted %0d clk, expected %0d", p, ms_on[p], ON_CLK); end
            if (p > 0) begin n_checks++; if (ms_off[p-1] != OFF_CLK) begin n_errors++; $display("FAIL single_off_len: space %0d lasted %0d clk, expected %0d", p - 1, ms_off[p-1], OFF_CLK); end end
        end
        m_pend[e] = 1'b0; m_last = e;
        @(negedge clk);
        n_checks++; if (served !== 4'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL single_after: served=%b busy=%b, expected 0000/0", served, busy); end
    endtask

    task automatic test_rereq;
        for (int c = 0; c < 2; c++) begin
            logic [3:0] rr_first;
            bit first;
            rr_first = (c == 0) ? 4'b0001 : 4'b0101;
            first = 1;
            @(negedge clk);
            req = 4'b0001; m_pend[0] = 1'b1;
            while (m_pend != 0) begin
                int e;
                logic [3:0] rr;
                logic [3:0] ex_srv;
                e = rr_pick(m_pend, m_last);
                ex_srv = 4'b0001 << e;
                rr = first ? rr_first : 4'b0;
                measure_service(4'b0, rr, LIMIT);
                n_checks++; if (ms_timeout || ms_id != e) begin n_errors++; $display("FAIL rereq_grant: got id=%0d timeout=%0b, expected id=%0d", ms_id, ms_timeout, e); end
                n_checks++; if (ms_pulses != e + 1) begin n_errors++; $display("FAIL rereq_pulses: got %0d, expected %0d", ms_pulses, e + 1); end
                n_checks++; if (ms_served !== ex_srv) begin n_errors++; $display("FAIL rereq_served: got %b, expected %b", ms_served, ex_srv); end
                n_checks++; if (ms_gap != DARK_CLK || ms_busy_bad != 0) begin n_errors++; $display("FAIL rereq_tail: dark=%0d busy_bad=%0d, expected %0d/0", ms_gap, ms_busy_bad, DARK_CLK); end
                for (int p = 0; p < ms_pulses && p < 8; p++) begin
                    n_checks++; if ((p == 0) ? (ms_on[p] < ON_FIRST_MIN || ms_on[p] > ON_CLK) : (ms_on[p] != ON_CLK)) begin n_errors++; $display("FAIL rereq_on_len: pulse %0d lasted %0d clk, expected %0d", p, ms_on[p], ON_CLK); end
                end
                m_pend = (m_pend & ~ex_srv) | rr; m_last = e; first = 0;
            end
        end
    endtask

    task automatic test_abort;
        int rises, bad, e;
        bit prev_on, seen;
        logic [3:0] ex_srv;
        @(negedge clk);
        req = 4'b0010; m_pend[1] = 1'b1;
        rises = 0; prev_on = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            req = '0;
            if (led_o === LED_ON && !prev_on) rises++;
            prev_on = (led_o === LED_ON);
            if (rises == 2) seen = 1;
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL abort_reach: saw %0d pulses, expected 2", rises); end
        en = 1'b0;
        @(negedge clk);
        n_checks++; if (led_o !== LED_DARK) begin n_errors++; $display("FAIL abort_led: got %b, expected 1", led_o); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        bad = (served !== 4'b0) ? 1 : 0;
        repeat (12) begin
            @(negedge clk);
            if (served !== 4'b0 || led_o !== LED_DARK || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL abort_quiet: %0d active cycles, expected 0", bad); end
        n_checks++; if (grant_id !== 2'd1) begin n_errors++; $display("FAIL abort_grant: got %0d, expected 1", grant_id); end
        m_last = 1;
        en = 1'b1;
        e = rr_pick(m_pend, m_last);
        ex_srv = 4'b0001 << e;
        measure_service(4'b0, 4'b0, LIMIT);
        n_checks++; if (ms_timeout || ms_id != e) begin n_errors++; $display("FAIL abort_regrant: got id=%0d timeout=%0b, expected id=%0d", ms_id, ms_timeout, e); end
        n_checks++; if (ms_pulses != 2) begin n_errors++; $display("FAIL abort_pulses: got %0d, expected 2", ms_pulses); end
        n_checks++; if (ms_served !== ex_srv) begin n_errors++; $display("FAIL abort_served: got %b, expected %b", ms_served, ex_srv); end
        for (int p = 0; p < ms_pulses && p < 8; p++) begin
            n_checks++; if ((p == 0) ? (ms_on[p] < ON_FIRST_MIN || ms_on[p] > ON_CLK) : (ms_on[p] != ON_CLK)) begin n_errors++; $display("FAIL abort_on_len: pulse %0d lasted %0d clk, expected %0d", p, ms_on[p], ON_CLK); end
        end
        m_pend[e] = 1'b0; m_last = e;
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        req = 4'hF; m_pend = 4'hF;
        for (int s = 0; s < 6; s++) begin
            int e;
            logic [3:0] ex_srv;
            e = rr_pick(m_pend, m_last);
            ex_srv = 4'b0001 << e;
            measure_service(4'hF, 4'b0, LIMIT);
            n_checks++; if (ms_timeout || ms_id != e) begin n_errors++; $display("FAIL all_grant: service %0d got id=%0d timeout=%0b, expected id=%0d", s, ms_id, ms_timeout, e); end
            n_checks++; if (ms_pulses != e + 1) begin n_errors++; $display("FAIL all_pulses: got %0d, expected %0d", ms_pulses, e + 1); end
            n_checks++; if (ms_served !== ex_srv || ms_end_busy !== 1'b0) begin n_errors++; $display("FAIL all_served: got %b busy=%b, expected %b busy=0", ms_served, ms_end_busy, ex_srv); end
            if (s > 0) begin n_checks++; if (ms_pre_idle != 0) begin n_errors++; $display("FAIL all_idle_gap: %0d extra idle clk, expected 0", ms_pre_idle); end end
            m_last = e;
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        req = '0;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midreset_pre: busy=%b, expected 1", busy); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (led_o !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL midreset_out: led=%b busy=%b, expected 1/0", led_o, busy); end
        n_checks++; if (served !== 4'b0 || grant_id !== 2'd3) begin n_errors++; $display("FAIL midreset_state: served=%b grant=%0d, expected 0000/3", served, grant_id); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        m_pend = '0; m_last = 3;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (led_o !== LED_DARK || busy !== 1'b0 || served !== 4'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL midreset_idle: %0d active cycles, expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_rereq();
        test_abort();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
